// File: rtl/nanorv32_tcm_shared_arb.sv
// Arbiter sharing one TCM controller port between the nanorv32 code (M0) and data (M1) masters.
// Data has fixed priority; a starvation counter forces a code grant; grants stay locked through wait states.
module nanorv32_tcm_shared_arb #(
  parameter int unsigned AW         = 13,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic [31:0]   m0_rdata,
  output logic          m0_early_ready,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_bytesel,
  output logic [31:0]   m1_rdata,
  output logic          m1_early_ready,
  output logic          tcm_en,
  output logic [AW-1:0] tcm_addr,
  output logic [31:0]   tcm_din,
  output logic [3:0]    tcm_bytesel,
  input  logic [31:0]   tcm_dout,
  input  logic          tcm_ready_nxt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  owner_t     rd_owner, rd_owner_nxt;
  owner_t     gnt;
  logic [3:0] starve_cnt, starve_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      rd_owner   <= OWN_NONE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rd_owner   <= rd_owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Grant selection, TCM port steering and acceptance bookkeeping
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    rd_owner_nxt   = OWN_NONE;
    starve_nxt     = starve_cnt;
    gnt            = OWN_NONE;
    tcm_en         = 1'b0;
    tcm_addr       = '0;
    tcm_din        = 32'd0;
    tcm_bytesel    = 4'd0;
    m0_early_ready = 1'b0;
    m1_early_ready = 1'b0;

    case (state)
      IDLE: begin
        if (m0_req && (!m1_req || starve_cnt == STARVE_LIM)) gnt = OWN_M0;
        else if (m1_req)                                      gnt = OWN_M1;
      end
      WAIT:    gnt = owner;
      default: gnt = OWN_NONE;
    endcase

    if (gnt == OWN_M0) begin
      tcm_en   = 1'b1;
      tcm_addr = m0_addr;
    end else if (gnt == OWN_M1) begin
      tcm_en      = 1'b1;
      tcm_addr    = m1_addr;
      tcm_din     = m1_wdata;
      tcm_bytesel = m1_bytesel;
    end

    if (gnt != OWN_NONE) begin
      if (tcm_ready_nxt) begin
        m0_early_ready = (gnt == OWN_M0);
        m1_early_ready = (gnt == OWN_M1);
        rd_owner_nxt   = gnt;
        state_nxt      = IDLE;
        owner_nxt      = OWN_NONE;
        // Count data wins only while code is actually waiting
        if (gnt == OWN_M0)                starve_nxt = 4'd0;
        else if (!m0_req)                 starve_nxt = 4'd0;
        else if (starve_cnt >= STARVE_LIM) starve_nxt = STARVE_LIM;
        else                              starve_nxt = starve_cnt + 4'd1;
      end else begin
        state_nxt = WAIT;
        owner_nxt = gnt;
      end
    end

    // A reset cycle presents nothing and acknowledges nothing
    if (rst) begin
      tcm_en         = 1'b0;
      tcm_addr       = '0;
      tcm_din        = 32'd0;
      tcm_bytesel    = 4'd0;
      m0_early_ready = 1'b0;
      m1_early_ready = 1'b0;
    end
  end

  assign m0_rdata = (!rst && rd_owner == OWN_M0) ? tcm_dout : 32'd0;
  assign m1_rdata = (!rst && rd_owner == OWN_M1) ? tcm_dout : 32'd0;

endmodule

// File: tb/tb_nanorv32_tcm_shared_arb.sv
// Self-checking bench: constant vector table, directed wait/starve/reset sequences, and a
// protocol-respecting random run scored against a transaction-level model.
module tb_nanorv32_tcm_shared_arb;

  localparam int unsigned AW = 13;
  localparam int unsigned SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_rdata, m1_rdata, m1_wdata, tcm_din, tcm_dout;
  logic          m0_early_ready, m1_early_ready, tcm_en, tcm_ready_nxt;
  logic [3:0]    m1_bytesel, tcm_bytesel;
  logic [AW-1:0] tcm_addr;

  int checks = 0;
  int errors = 0;

  nanorv32_tcm_shared_arb #(.AW(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_early_ready(m0_early_ready),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_bytesel(m1_bytesel),
    .m1_rdata(m1_rdata), .m1_early_ready(m1_early_ready),
    .tcm_en(tcm_en), .tcm_addr(tcm_addr), .tcm_din(tcm_din), .tcm_bytesel(tcm_bytesel),
    .tcm_dout(tcm_dout), .tcm_ready_nxt(tcm_ready_nxt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one cycle of inputs at the falling edge, leave time for outputs to settle
  task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic r1,
                       input logic [AW-1:0] a1, input logic [31:0] wd, input logic [3:0] bs,
                       input logic rdy, input logic [31:0] d);
    @(negedge clk);
    m0_req = r0; m0_addr = a0; m1_req = r1; m1_addr = a1;
    m1_wdata = wd; m1_bytesel = bs; tcm_ready_nxt = rdy; tcm_dout = d;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; tcm_ready_nxt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic          r0;
    logic [AW-1:0] a0;
    logic          r1;
    logic [AW-1:0] a1;
    logic [31:0]   wd;
    logic [3:0]    bs;
    logic          en;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [3:0]    tbs;
    logic          e0;
    logic          e1;
  } vec_t;

  vec_t vt[9];

  // Random-run model state: pending transactions and arbitration history
  logic          p0, p1;
  logic [AW-1:0] pa0, pa1;
  logic [31:0]   pwd;
  logic [3:0]    pbs;
  int            locked;   // 0 none, 1 code, 2 data
  int            m1_streak;
  int            last_acc;

  initial begin
    rst = 1'b1;
    m0_req = 0; m1_req = 0; m0_addr = '0; m1_addr = '0;
    m1_wdata = '0; m1_bytesel = '0; tcm_ready_nxt = 0; tcm_dout = '0;

    vt[0] = '{0, 13'h0000, 0, 13'h0000, 32'h0,        4'h0, 0, 13'h0000, 32'h0,        4'h0, 0, 0};
    vt[1] = '{1, 13'h0040, 0, 13'h0000, 32'h0,        4'h0, 1, 13'h0040, 32'h0,        4'h0, 1, 0};
    vt[2] = '{0, 13'h0000, 1, 13'h0123, 32'h11112222, 4'h0, 1, 13'h0123, 32'h11112222, 4'h0, 0, 1};
    vt[3] = '{0, 13'h0000, 1, 13'h1FFF, 32'hDEADBEEF, 4'h3, 1, 13'h1FFF, 32'hDEADBEEF, 4'h3, 0, 1};
    vt[4] = '{1, 13'h0010, 1, 13'h0020, 32'hCAFEF00D, 4'hF, 1, 13'h0020, 32'hCAFEF00D, 4'hF, 0, 1};
    vt[5] = '{1, 13'h0011, 1, 13'h0021, 32'h0,        4'h0, 1, 13'h0021, 32'h0,        4'h0, 0, 1};
    vt[6] = '{1, 13'h0012, 0, 13'h03FF, 32'h55,       4'hF, 1, 13'h0012, 32'h0,        4'h0, 1, 0};
    vt[7] = '{0, 13'h0000, 1, 13'h0007, 32'h0,        4'h0, 1, 13'h0007, 32'h0,        4'h0, 0, 1};
    vt[8] = '{0, 13'h0000, 0, 13'h0000, 32'h0,        4'h0, 0, 13'h0000, 32'h0,        4'h0, 0, 0};

    do_reset();

    // Reset state with a live dout: nothing presented, nothing returned
    drive(0, '0, 0, '0, '0, '0, 1, 32'hA5A5A5A5);
    check("reset_tcm_en", 64'(tcm_en), 64'd0);
    check("reset_early", 64'({m0_early_ready, m1_early_ready}), 64'd0);
    check("reset_rdata", 64'({m0_rdata, m1_rdata}), 64'd0);

    // Single-cycle vector table, always ready; rdata checked against the previous row's winner
    begin
      logic pe0, pe1;
      logic [31:0] d;
      pe0 = 0; pe1 = 0;
      for (int i = 0; i < 9; i++) begin
        d = $urandom;
        drive(vt[i].r0, vt[i].a0, vt[i].r1, vt[i].a1, vt[i].wd, vt[i].bs, 1'b1, d);
        check($sformatf("vec%0d_tcm", i), {tcm_en, tcm_bytesel, 19'(tcm_addr), tcm_din},
              {vt[i].en, vt[i].tbs, 19'(vt[i].addr), vt[i].din});
        check($sformatf("vec%0d_early", i), 64'({m0_early_ready, m1_early_ready}),
              64'({vt[i].e0, vt[i].e1}));
        check($sformatf("vec%0d_rdata", i), {m0_rdata, m1_rdata},
              {pe0 ? d : 32'd0, pe1 ? d : 32'd0});
        pe0 = vt[i].e0; pe1 = vt[i].e1;
      end
    end

    // Starvation: both request continuously, code wins every fifth access
    do_reset();
    begin
      logic [5:0] want1;
      want1 = 6'b101111;
      for (int i = 0; i < 6; i++) begin
        drive(1, 13'h0100, 1, 13'h0200, 32'h0, 4'h0, 1, 32'h0);
        check($sformatf("starve%0d", i), 64'({m0_early_ready, m1_early_ready}),
              64'({~want1[i], want1[i]}));
      end
    end

    // Wait states: code locked at 0x40 for three stalled cycles, data queued behind it
    do_reset();
    drive(1, 13'h0040, 0, 13'h0100, 32'h0, 4'h0, 0, 32'h0);
    check("wait_c0", {tcm_en, 19'(tcm_addr), m0_early_ready, m1_early_ready}, {1'b1, 19'h40, 2'b00});
    for (int i = 1; i < 3; i++) begin
      drive(1, 13'h0040, 1, 13'h0100, 32'h0, 4'h0, 0, 32'h0);
      check($sformatf("wait_c%0d", i), {tcm_en, 19'(tcm_addr), m0_early_ready, m1_early_ready},
            {1'b1, 19'h40, 2'b00});
    end
    drive(1, 13'h0040, 1, 13'h0100, 32'h0, 4'h0, 1, 32'h0);
    check("wait_c3", {tcm_en, 19'(tcm_addr), m0_early_ready, m1_early_ready}, {1'b1, 19'h40, 2'b10});
    drive(0, 13'h0000, 1, 13'h0100, 32'h0, 4'h0, 1, 32'h12345678);
    check("wait_c4", {tcm_en, 19'(tcm_addr), m0_early_ready, m1_early_ready}, {1'b1, 19'h100, 2'b01});
    check("wait_c4_rdata", {m0_rdata, m1_rdata}, {32'h12345678, 32'h0});

    // Reset mid-WAIT after building up starvation; counter must restart from zero
    for (int i = 0; i < 3; i++) drive(1, 13'h0001, 1, 13'h0002, 32'h0, 4'h0, 1, 32'h0);
    drive(0, 13'h0000, 1, 13'h0055, 32'h0, 4'h0, 0, 32'h0);
    check("rstwait_pre", 64'({tcm_en, m1_early_ready}), 64'b10);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rstwait_during", 64'({tcm_en, m0_early_ready, m1_early_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m1_req = 1'b0; tcm_ready_nxt = 1'b1; tcm_dout = 32'hFFFF0000;
    #2;
    check("rstwait_after", {tcm_en, m0_early_ready, m1_early_ready, m0_rdata, m1_rdata}, 67'd0);
    drive(1, 13'h0001, 1, 13'h0002, 32'h0, 4'h0, 1, 32'h0);
    drive(1, 13'h0001, 1, 13'h0002, 32'h0, 4'h0, 1, 32'h0);
    check("rstwait_starve_cleared", 64'({m0_early_ready, m1_early_ready}), 64'b01);

    // Randomized protocol-respecting traffic against a transaction-level model
    do_reset();
    p0 = 0; p1 = 0; pa0 = '0; pa1 = '0; pwd = '0; pbs = '0;
    locked = 0; m1_streak = 0; last_acc = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int g;
      logic rdy;
      logic [31:0] d;
      if (!p0 && ($urandom % 3 != 0)) begin p0 = 1; pa0 = AW'($urandom); end
      if (!p1 && ($urandom % 3 != 0)) begin
        p1 = 1; pa1 = AW'($urandom); pwd = $urandom;
        pbs = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      end
      rdy = ($urandom % 4 != 0);
      d = $urandom;
      drive(p0, pa0, p1, pa1, pwd, pbs, rdy, d);

      if (locked != 0)                        g = locked;
      else if (p0 && (!p1 || m1_streak == SM)) g = 1;
      else if (p1)                            g = 2;
      else                                    g = 0;

      check("rnd_tcm", {tcm_en, tcm_bytesel, 19'(tcm_addr), tcm_din},
            (g == 1) ? {1'b1, 4'h0, 19'(pa0), 32'h0} :
            (g == 2) ? {1'b1, pbs, 19'(pa1), pwd} : 56'd0);
      check("rnd_early", 64'({m0_early_ready, m1_early_ready}),
            64'({rdy && g == 1, rdy && g == 2}));
      check("rnd_rdata", {m0_rdata, m1_rdata},
            {(last_acc == 1) ? d : 32'd0, (last_acc == 2) ? d : 32'd0});

      if (g != 0 && rdy) begin
        if (g == 1)      m1_streak = 0;
        else if (p0)     m1_streak = (m1_streak < SM) ? m1_streak + 1 : SM;
        else             m1_streak = 0;
        if (g == 1) p0 = 0; else p1 = 0;
        locked = 0;
        last_acc = g;
      end else begin
        locked = g;
        last_acc = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
